// File: rtl/axi_write_response_router_pkg.sv
// Shared crossbar definitions for the B-channel return path:
// port counts, ID widths, master tag encoding and BRESP codes.
package axi_write_response_router_pkg;

  localparam int NUM_S    = 8;
  localparam int NUM_M    = 3;
  localparam int ID_BITS  = 4;
  localparam int IDS_BITS = 8;
  localparam int TAG_BITS = IDS_BITS - ID_BITS;
  localparam int SEL_BITS = $clog2(NUM_S);

  // Tags prepended on AW by the write-address mux
  localparam logic [TAG_BITS-1:0] TAG_M0 = TAG_BITS'(0);
  localparam logic [TAG_BITS-1:0] TAG_M1 = TAG_BITS'(1);
  localparam logic [TAG_BITS-1:0] TAG_M2 = TAG_BITS'(2);

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } bresp_e;

  // Adds the number of set bits in hits to acc, clamping at 255
  function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [NUM_S-1:0] hits);
    logic [8:0] sum;
    sum = {1'b0, acc};
    for (int i = 0; i < NUM_S; i++) begin
      sum = sum + 9'(hits[i]);
    end
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/axi_write_response_router_b_rr_arbiter.sv
// Round-robin arbiter over the slave ports for one master; the priority
// pointer moves to just past the winner whenever a grant is consumed.
module axi_write_response_router_b_rr_arbiter
  import axi_write_response_router_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_S-1:0]    req,
  input  logic                advance,
  output logic [NUM_S-1:0]    grant,
  output logic [SEL_BITS-1:0] grant_idx,
  output logic                any_req
);

  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS-1:0] idx;

  // Scan from furthest to nearest so the request closest to ptr wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    any_req   = |req;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      idx = SEL_BITS'((int'(ptr) + i) % NUM_S);
      if (req[idx]) begin
        grant_idx = idx;
      end
    end
    if (any_req) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == SEL_BITS'(NUM_S - 1)) ? '0 : grant_idx + SEL_BITS'(1);
    end
  end

endmodule

// File: rtl/axi_write_response_router.sv
// B-channel return path: routes tagged slave write responses back to the
// originating master through a per-master RR arbiter and output register.
module axi_write_response_router
  import axi_write_response_router_pkg::*;
(
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_S*IDS_BITS-1:0] BID_S,
  input  logic [NUM_S*2-1:0]        BRESP_S,
  input  logic [NUM_S-1:0]          BVALID_S,
  output logic [NUM_S-1:0]          BREADY_S,
  output logic [NUM_M*ID_BITS-1:0]  BID_M,
  output logic [NUM_M*2-1:0]        BRESP_M,
  output logic [NUM_M-1:0]          BVALID_M,
  input  logic [NUM_M-1:0]          BREADY_M,
  output logic                      err_unrouted,
  output logic [7:0]                err_count
);

  localparam logic [TAG_BITS-1:0] MASTER_TAG [NUM_M] = '{TAG_M0, TAG_M1, TAG_M2};

  logic [TAG_BITS-1:0] slave_tag [NUM_S];
  logic [NUM_S-1:0]    req       [NUM_M];
  logic [NUM_S-1:0]    grant     [NUM_M];
  logic [SEL_BITS-1:0] grant_idx [NUM_M];
  logic [NUM_M-1:0]    any_req;
  logic [NUM_M-1:0]    can_load;
  logic [NUM_M-1:0]    load;
  logic [NUM_S-1:0]    unrouted;

  always_comb begin
    unrouted = '0;
    for (int m = 0; m < NUM_M; m++) begin
      req[m] = '0;
    end
    for (int k = 0; k < NUM_S; k++) begin
      slave_tag[k] = BID_S[k*IDS_BITS + ID_BITS +: TAG_BITS];
      unrouted[k]  = BVALID_S[k] && (int'(slave_tag[k]) >= NUM_M);
      for (int m = 0; m < NUM_M; m++) begin
        req[m][k] = BVALID_S[k] && (slave_tag[k] == MASTER_TAG[m]);
      end
    end
  end

  generate
    for (genvar m = 0; m < NUM_M; m++) begin : g_arb
      axi_write_response_router_b_rr_arbiter u_arb (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .req       (req[m]),
        .advance   (load[m]),
        .grant     (grant[m]),
        .grant_idx (grant_idx[m]),
        .any_req   (any_req[m])
      );
    end
  endgenerate

  // Unrouted responses are always sunk so a bad tag can never stall a slave
  always_comb begin
    BREADY_S = unrouted;
    can_load = '0;
    load     = '0;
    for (int m = 0; m < NUM_M; m++) begin
      can_load[m] = !BVALID_M[m] || BREADY_M[m];
      load[m]     = can_load[m] && any_req[m];
      if (load[m]) begin
        BREADY_S = BREADY_S | grant[m];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      BID_M        <= '0;
      BRESP_M      <= '0;
      BVALID_M     <= '0;
      err_unrouted <= 1'b0;
      err_count    <= '0;
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        if (load[m]) begin
          BID_M[m*ID_BITS +: ID_BITS] <= BID_S[int'(grant_idx[m])*IDS_BITS +: ID_BITS];
          BRESP_M[m*2 +: 2]           <= BRESP_S[int'(grant_idx[m])*2 +: 2];
          BVALID_M[m]                 <= 1'b1;
        end else if (BREADY_M[m]) begin
          BVALID_M[m] <= 1'b0;
        end
      end
      if (|unrouted) begin
        err_unrouted <= 1'b1;
      end
      err_count <= sat_add(err_count, unrouted);
    end
  end

endmodule

// File: doc/axi_write_response_router.md
Name: axi_write_response_router

Overview:
- Crossbar B-channel return path: routes write responses from 8 slave ports back to 3 master ports.
- Decodes the master tag in the upper nibble of the extended slave-side BID. Strips the tag and returns the original 4-bit ID.
- Per master: round-robin arbitration among slaves with pending responses for that master, then a 1-entry output register.
- Companion of the write-address mux, which prepends the tag on AW (M0=0, M1=1, M2=2).

Parameters:
- NUM_S, 8, number of slave ports
- NUM_M, 3, number of master ports
- ID_BITS, 4, master-side ID width
- IDS_BITS, 8, slave-side ID width; tag = BID[IDS_BITS-1:ID_BITS]

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- BID_S  in  NUM_S*IDS_BITS  slave BIDs packed; slave k at [k*IDS_BITS +: IDS_BITS]
- BRESP_S  in  NUM_S*2  slave BRESPs packed
- BVALID_S  in  NUM_S  slave BVALIDs
- BREADY_S  out  NUM_S  BREADY to slaves
- BID_M  out  NUM_M*ID_BITS  master BIDs packed
- BRESP_M  out  NUM_M*2  master BRESPs packed
- BVALID_M  out  NUM_M  master BVALIDs
- BREADY_M  in  NUM_M  master BREADYs
- err_unrouted  out  1  sticky flag: a response carried tag >= NUM_M
- err_count  out  8  saturating count of dropped unrouted responses

Behaviour:
- Reset (async, ARESETn=0): BVALID_M=0, BID_M=0, BRESP_M=0, all RR pointers=0, err_unrouted=0, err_count=0. BREADY_S is combinational and is 0 while all BVALID_S=0.
- Request matrix: req[m][k] = BVALID_S[k] && tag(k)==m. A slave targets exactly one master, so slaves never conflict across masters.
- Per-master output register state: EMPTY (BVALID_M[m]=0) or FULL (BVALID_M[m]=1).
- can_load[m] = EMPTY || (FULL && BREADY_M[m]).
- Arbitration for master m:
  - Round-robin over k, starting at ptr[m] and wrapping NUM_S-1 -> 0.
  - Winner w = first k with req[m][k].
  - Grant is combinational: BREADY_S[w]=can_load[m] && any req[m].
- Load (rising edge, when can_load && any req):
  - BID_M[m] <= BID_S[w][ID_BITS-1:0]; BRESP_M[m] <= BRESP_S[w]; BVALID_M[m] <= 1.
  - ptr[m] <= (w+1) mod NUM_S.
- Drain: FULL && BREADY_M[m] && no req -> BVALID_M[m] <= 0. FULL && BREADY_M[m] && req -> reload the same cycle (full throughput, no bubble).
- FULL && !BREADY_M[m]:
  - Hold BID/BRESP/BVALID stable.
  - BREADY_S low for all slaves targeting m.
  - ptr unchanged.
- Latency: slave handshake at edge N -> BVALID_M high after edge N; 1 cycle.
- Unrouted (tag >= NUM_M):
  - BREADY_S[k]=1 combinationally; response dropped.
  - err_unrouted <= 1 (sticky until reset).
  - err_count increments once per handshake, saturating at 255.
  - Several unrouted slaves in one cycle: err_count adds popcount, saturating.
- BREADY_S[k]=0 for any slave with BVALID_S[k]=0.
- Outputs do not depend combinationally on BREADY_M, except via BREADY_S (can_load path).
- Reset mid-transfer: pending FULL entries are lost and BVALID_M drops immediately. This is acceptable; system reset is global.

Decomposition:
- Shared package (crossbar defs) holds: NUM_S, NUM_M, ID_BITS, IDS_BITS, the tag encoding constants TAG_M0=0, TAG_M1=1, TAG_M2=2, and the BRESP codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- One natural sub-module, b_rr_arbiter: NUM_S-request round-robin arbiter with ptr register, advance enable, and one-hot grant. Instantiated NUM_M times.

Test Plan:
- Single response: S3 drives BID=8'h15, BRESP=2'b00, BREADY_M1=1 -> BREADY_S[3] same cycle; next cycle BVALID_M[1]=1, BID_M1=4'h5, BRESP_M1=00; M0/M2 stay idle.
- RR fairness: S0, S2, S5 all hold valid with tag 0, BREADY_M0=1 constantly -> grants in order S0, S2, S5 on consecutive cycles. Repeat with ptr=3 -> order S5, S0, S2.
- Backpressure: M2 BREADY=0 for 4 cycles while S6 (BID=8'h2A, BRESP=10) and S7 wait -> BID_M2=4'hA held stable, BREADY_S[6]=BREADY_S[7]=0. On BREADY_M2=1, S7 is loaded in the same cycle.
- Parallel masters: S1 tag0, S4 tag1, S7 tag2 valid together -> all three BREADY_S high in one cycle; next cycle all three BVALID_M high with correct IDs.
- Unrouted: S2 sends BID=8'h31 for 300 responses -> each accepted immediately, no BVALID_M, err_unrouted=1, err_count saturates at 255.
- Async reset while BVALID_M[0]=1 and BREADY_M0=0 -> BVALID_M[0]=0 without a clock edge; after release, a new S0 response routes normally with ptr=0.
